// File: rtl/prio_irq_ctrl.sv
// 8-level priority interrupt controller: latches falling request edges, arbitrates
// highest-index-wins among unmasked pending lines, and holds the vector until EOI.
module prio_irq_ctrl #(
  parameter int N = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N-1:0]            req_n,
  input  logic [N-1:0]            mask,
  output logic                    int_n,
  input  logic                    inta,
  output logic [$clog2(N)-1:0]    vec,
  output logic                    vec_valid,
  input  logic                    eoi,
  output logic                    busy,
  output logic [N-1:0]            pend
);

  localparam int VW = $clog2(N);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    req_q;
  logic [N-1:0]    pend_q, pend_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic            vec_valid_q, vec_valid_d;
  logic            int_n_q, int_n_d;
  logic            busy_q, busy_d;
  logic [N-1:0]    elig_s;
  logic [N-1:0]    set_s;
  logic [N-1:0]    clr_s;
  logic [VW-1:0]   win_s;
  logic            take_s;

  // Highest set index wins; bit 0 is the lowest priority.
  function automatic logic [VW-1:0] prio_enc(input logic [N-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = VW'(i);
      end
    end
    return r;
  endfunction

  assign elig_s = pend_q & ~mask;
  assign set_s  = req_q & ~req_n;
  assign win_s  = prio_enc(elig_s);
  assign take_s = (state_q == ST_ASSERT) && inta && (elig_s != '0);

  // State register and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '1;
      pend_q      <= '0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      int_n_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_n;
      pend_q      <= pend_d;
      vec_q       <= vec_d;
      vec_valid_q <= vec_valid_d;
      int_n_q     <= int_n_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state logic; an acknowledge with nothing eligible falls back to idle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (elig_s != '0) state_d = ST_ASSERT;
        else              state_d = ST_IDLE;
      end
      ST_ASSERT: begin
        if (take_s)              state_d = ST_SERVICE;
        else if (elig_s == '0)   state_d = ST_IDLE;
        else                     state_d = ST_ASSERT;
      end
      ST_SERVICE: begin
        if (eoi) state_d = ST_IDLE;
        else     state_d = ST_SERVICE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output next values; a coincident new edge on the winner re-sets its pend bit.
  always_comb begin
    if (take_s) begin
      clr_s       = {{(N-1){1'b0}}, 1'b1} << win_s;
      vec_d       = win_s;
      vec_valid_d = 1'b1;
    end else if ((state_q == ST_SERVICE) && eoi) begin
      clr_s       = '0;
      vec_d       = vec_q;
      vec_valid_d = 1'b0;
    end else begin
      clr_s       = '0;
      vec_d       = vec_q;
      vec_valid_d = vec_valid_q;
    end
    pend_d  = (pend_q & ~clr_s) | set_s;
    int_n_d = (state_d != ST_ASSERT);
    busy_d  = (state_d == ST_SERVICE);
  end

  assign int_n     = int_n_q;
  assign vec       = vec_q;
  assign vec_valid = vec_valid_q;
  assign busy      = busy_q;
  assign pend      = pend_q;

endmodule

// File: tb/tb_prio_irq_ctrl.sv
// Bench for prio_irq_ctrl: directed test-plan scenarios followed by random traffic,
// every cycle compared against a rule-level reference model.
module tb_prio_irq_ctrl;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_n;
  logic [7:0] mask;
  logic       int_n;
  logic       inta;
  logic [2:0] vec;
  logic       vec_valid;
  logic       eoi;
  logic       busy;
  logic [7:0] pend;

  int n_checks;
  int n_fail;

  // Reference model: phase 0 = waiting, 1 = interrupt raised, 2 = in service.
  logic [7:0] m_pend;
  logic [7:0] m_prev;
  int         m_phase;
  int         m_vec;
  logic       m_vv;

  prio_irq_ctrl #(.N(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_n     (req_n),
    .mask      (mask),
    .int_n     (int_n),
    .inta      (inta),
    .vec       (vec),
    .vec_valid (vec_valid),
    .eoi       (eoi),
    .busy      (busy),
    .pend      (pend)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance the model by one clock using the current inputs, then clock the DUT and compare.
  task automatic step();
    logic [7:0] elig;
    logic [7:0] edges;
    int         w;
    if (!rst_n) begin
      m_pend  = 8'h00;
      m_prev  = 8'hFF;
      m_phase = 0;
      m_vec   = 0;
      m_vv    = 1'b0;
    end else begin
      edges = m_prev & ~req_n;
      elig  = m_pend & ~mask;
      w = -1;
      for (int i = 7; i >= 0; i--) begin
        if (w < 0 && elig[i]) w = i;
      end
      if (m_phase == 1 && inta && w >= 0) begin
        m_vec     = w;
        m_vv      = 1'b1;
        m_pend[w] = 1'b0;
        m_phase   = 2;
      end else if (m_phase == 1 && w < 0) begin
        m_phase = 0;
      end else if (m_phase == 0 && w >= 0) begin
        m_phase = 1;
      end else if (m_phase == 2 && eoi) begin
        m_vv    = 1'b0;
        m_phase = 0;
      end
      m_pend = m_pend | edges;
      m_prev = req_n;
    end
    @(posedge clk);
    #1;
    check_eq("int_n", 32'(int_n), 32'(m_phase != 1));
    check_eq("busy", 32'(busy), 32'(m_phase == 2));
    check_eq("vec", 32'(vec), 32'(m_vec));
    check_eq("vec_valid", 32'(vec_valid), 32'(m_vv));
    check_eq("pend", 32'(pend), 32'(m_pend));
  endtask

  // Serve one already-pending interrupt: raise, acknowledge, end-of-interrupt.
  task automatic serve(input int exp_vec, input logic [7:0] exp_pend);
    step();
    check_eq("srv_int_low", 32'(int_n), 32'd0);
    inta = 1'b1;
    step();
    inta = 1'b0;
    check_eq("srv_vec", 32'(vec), 32'(exp_vec));
    check_eq("srv_pend", 32'(pend), 32'(exp_pend));
    check_eq("srv_busy", 32'(busy), 32'd1);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    check_eq("srv_eoi_busy", 32'(busy), 32'd0);
    check_eq("srv_eoi_vv", 32'(vec_valid), 32'd0);
  endtask

  initial begin
    logic [7:0] r;
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    req_n = 8'hFF;
    mask  = 8'h00;
    inta  = 1'b0;
    eoi   = 1'b0;

    // Reset and idle
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("rst_int_n", 32'(int_n), 32'd1);
    check_eq("rst_pend", 32'(pend), 32'h00);

    // Single request on line 3
    req_n = 8'hF7;
    step();
    check_eq("single_pend", 32'(pend), 32'h08);
    step();
    check_eq("single_int", 32'(int_n), 32'd0);
    step();
    inta = 1'b1;
    step();
    inta = 1'b0;
    check_eq("single_vec", 32'(vec), 32'd3);
    check_eq("single_vv", 32'(vec_valid), 32'd1);
    check_eq("single_pend0", 32'(pend), 32'h00);
    step();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    check_eq("single_busy", 32'(busy), 32'd0);
    req_n = 8'hFF;
    step();

    // Priority and back-to-back: lines 0, 5, 7
    req_n = 8'h5E;
    step();
    check_eq("prio_pend", 32'(pend), 32'hA1);
    serve(7, 8'h21);
    serve(5, 8'h01);
    serve(0, 8'h00);
    req_n = 8'hFF;
    step();

    // Mask: line 7 masked, line 2 served first
    mask  = 8'h80;
    req_n = 8'h7B;
    step();
    serve(2, 8'h80);
    step();
    check_eq("mask_idle", 32'(int_n), 32'd1);
    mask = 8'h00;
    serve(7, 8'h00);
    req_n = 8'hFF;
    step();

    // Masking the only pending line while raised drops back to idle
    req_n = 8'hFE;
    step();
    step();
    check_eq("mask_assert", 32'(int_n), 32'd0);
    mask = 8'h01;
    step();
    check_eq("mask_drop_int", 32'(int_n), 32'd1);
    check_eq("mask_drop_vv", 32'(vec_valid), 32'd0);
    check_eq("mask_keep_pend", 32'(pend), 32'h01);
    mask = 8'h00;
    serve(0, 8'h00);
    req_n = 8'hFF;
    step();

    // Edge collision on line 4 at acknowledge, plus ignored inta/eoi
    req_n = 8'hEF;
    step();
    step();
    req_n = 8'hFF;
    step();
    req_n = 8'hEF;
    inta  = 1'b1;
    step();
    check_eq("coll_vec", 32'(vec), 32'd4);
    check_eq("coll_pend", 32'(pend), 32'h10);
    step();
    step();
    inta = 1'b0;
    check_eq("ign_inta_svc", 32'(busy), 32'd1);
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    serve(4, 8'h00);
    step();
    inta = 1'b1;
    eoi  = 1'b1;
    step();
    inta = 1'b0;
    eoi  = 1'b0;
    check_eq("ign_idle_int", 32'(int_n), 32'd1);
    check_eq("ign_idle_vec", 32'(vec), 32'd4);

    // Reset mid-service with line 1 held low
    req_n = 8'hBF;
    step();
    step();
    inta = 1'b1;
    step();
    inta = 1'b0;
    check_eq("midrst_vec", 32'(vec), 32'd6);
    req_n = 8'hFD;
    rst_n = 1'b0;
    step();
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_vec0", 32'(vec), 32'd0);
    rst_n = 1'b1;
    step();
    check_eq("midrst_pend", 32'(pend), 32'h02);
    step();
    check_eq("midrst_int", 32'(int_n), 32'd0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      r = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req_n = req_n ^ (r & 8'($urandom));
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom) & 8'($urandom);
      inta  = ($urandom_range(0, 2) == 0);
      eoi   = ($urandom_range(0, 2) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_irq_ctrl.md
# prio_irq_ctrl

Sequenced 8-level priority interrupt controller built around the 74LS148 priority convention: active-low request lines, with the highest index winning. It latches request edges into a pending register, applies a mask, and raises one active-low interrupt. It resolves the winner when acknowledged and holds the vector until end-of-interrupt. It sits between the peripheral request lines and the CPU interrupt/acknowledge pins.

## Interface
- N, 8: number of request lines; must be a power of two, ≥ 2
- VW, $clog2(N): vector width; derived localparam, not overridable
- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_n  in  N  active-low interrupt requests, synchronous to clk; a 1→0 transition is a new request
- mask  in  N  1 = request line excluded from arbitration; it still latches into pend
- int_n  out  1  active-low interrupt to CPU, registered
- inta  in  1  acknowledge, single-cycle pulse
- vec  out  VW  index of the serviced request, registered
- vec_valid  out  1  vec holds a serviced index
- eoi  in  1  end-of-interrupt, single-cycle pulse
- busy  out  1  a request is in service
- pend  out  N  pending latch, registered

## Operation
- Edge detect:
  - req_q is the previous-cycle copy of req_n; it resets to all ones.
  - pend[i] sets when req_q[i]=1 and req_n[i]=0.
  - A line held low through reset is therefore latched once, one cycle after reset release.
- Eligible set: elig = pend & ~mask.
- Priority: the highest set index of elig wins, so bit N-1 is highest and bit 0 lowest.
- FSM states: IDLE, ASSERT, SERVICE.
  - **IDLE:** int_n=1, busy=0. If elig≠0, go to ASSERT.
  - **ASSERT:** int_n=0.
    - On inta: win = priority(elig) in that same cycle. vec←win, vec_valid←1, pend[win]←0, go to SERVICE.
    - If elig=0 and no inta (lines masked after assertion): go to IDLE. No vector is produced.
  - **SERVICE:** int_n=1, busy=1, vec held stable. No nesting: new requests only latch into pend.
    - On eoi: vec_valid←0, go to IDLE. vec keeps its last value.
- Ignored inputs:
  - inta outside ASSERT is ignored.
  - eoi outside SERVICE is ignored.
  - If inta and eoi are asserted together, each is evaluated against the current state only.
- Simultaneous set/clear on the same bit: if a new edge on req_n[win] coincides with its clear at inta, the set wins and pend[win] stays 1.
- Mask changes take effect combinationally on elig in the same cycle. Masking never clears pend.
- Reset:
  - rst_n=0 sampled at any edge forces state=IDLE, int_n=1, vec=0, vec_valid=0, busy=0, pend=0, req_q=all ones.
  - This applies in any state, including mid-SERVICE. The in-service request is discarded.

## Timing
- Request sampled low at edge k: pend[i]=1 after edge k. State becomes ASSERT and int_n=0 after edge k+1. Request-to-int_n latency is 2 cycles.
- inta sampled at edge m: after edge m, int_n=1, busy=1, vec_valid=1, vec valid, pend[win]=0.
- Winner selection uses elig as seen at edge m, not as it was when int_n first fell.
- eoi sampled at edge e: after edge e, busy=0, vec_valid=0.
  - If elig≠0, int_n=0 again after edge e+1, giving a 1-cycle minimum int_n high gap.
- Back-to-back service: the minimum period is 3 cycles per interrupt (ASSERT, SERVICE, IDLE), given inta and eoi each arrive one cycle after entry to their state.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- **Reset and idle:**
  - Stimulus: rst_n=0 for 2 cycles, req_n=8'hFF, mask=0.
  - Required: int_n=1, vec=0, vec_valid=0, busy=0, pend=8'h00. These hold while idle.
- **Single request:**
  - Stimulus: req_n=8'hF7 (line 3) at edge k; inta at k+3; eoi at k+5.
  - Required: pend=8'h08 after k; int_n=0 after k+1. After k+3: vec=3, vec_valid=1, busy=1, pend=8'h00. After k+5: busy=0.
- **Priority and back-to-back:**
  - Stimulus: req_n=8'h5E (lines 0, 5, 7) at once; service three times.
  - Required: vec sequence 7, 5, 0. pend goes 8'hA1 → 8'h21 → 8'h01 → 8'h00. int_n re-asserts 1 cycle after each eoi.
- **Mask:**
  - Stimulus: mask=8'h80, req_n=8'h7B (lines 2, 7).
  - Required: vec=2 on inta. pend=8'h80 remains. Clearing mask then yields int_n=0 and vec=7.
  - Also: masking the only pending line while in ASSERT returns to IDLE with int_n=1 and no vec_valid.
- **Edge collision and ignored inputs:**
  - Stimulus: line 4 toggles 0→1→0 so its new falling edge coincides with inta serving line 4.
  - Required: pend[4]=1 after inta.
  - Stimulus: inta pulsed while in IDLE or SERVICE, and eoi pulsed while in IDLE.
  - Required: no change to outputs.
- **Reset mid-service:**
  - Stimulus: in SERVICE with vec=6, assert rst_n=0 for 1 cycle while req_n[1]=0 is held.
  - Required: all outputs return to reset values. pend=8'h02 one cycle after release; int_n=0 the following cycle.
